// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing a 4:1 selector among four requesters.
// Each winner holds the selector for a bounded slice, followed by a two-cycle turnaround.
module mux_rr_scheduler #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic       preempt
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       sel_nxt;
    logic [3:0]       grant_nxt;
    logic             valid_nxt;
    logic             preempt_nxt;

    logic             have_winner;
    logic [1:0]       winner;
    logic             drop;
    logic             expiry;

    // State register plus all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            sel     <= 2'd0;
            grant   <= 4'b0000;
            valid   <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            sel     <= sel_nxt;
            grant   <= grant_nxt;
            valid   <= valid_nxt;
            preempt <= preempt_nxt;
        end
    end

    // Rotating priority search: first set request at or after ptr, wrapping
    always_comb begin
        have_winner = 1'b0;
        winner      = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!have_winner && req[ptr + 2'(k)]) begin
                have_winner = 1'b1;
                winner      = ptr + 2'(k);
            end
        end
    end

    assign drop   = ~req[sel] | ~en;
    assign expiry = (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && have_winner) state_nxt = GRANT;
            GRANT:   if (drop || expiry)    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Release and enable-low win over expiry, so preempt only flags a forced hand-off
    always_comb begin
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        sel_nxt     = sel;
        grant_nxt   = grant;
        valid_nxt   = valid;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (en && have_winner) begin
                    sel_nxt   = winner;
                    grant_nxt = 4'b0001 << winner;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    grant_nxt = 4'b0000;
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (drop || expiry) begin
                    grant_nxt   = 4'b0000;
                    valid_nxt   = 1'b0;
                    ptr_nxt     = sel + 2'd1;
                    preempt_nxt = ~drop;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                grant_nxt = 4'b0000;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that shares the design's 4:1 selector datapath among four requesters. It arbitrates the request lines and drives the selector's 2-bit select plus a valid/enable qualifier. Each winner holds the datapath for a bounded time slice, then a fixed turnaround gap follows. It sits between the `ui_in` request bits and the selector inside the top-level wrapper.

## Interface
- `HOLD_CYCLES`, default 4: maximum grant length in cycles; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: scheduler enable. When low, no new grant starts and any active grant is terminated.
- `req` input 4: per-requester request, level-sensitive; bit i is requester i.
- `sel` output 2: select for the 4:1 selector; encodes the current or last granted index.
- `grant` output 4: one-hot grant; all zero when no grant is active.
- `valid` output 1: high exactly when `grant` is non-zero; qualifies selector output.
- `preempt` output 1: one-cycle pulse when a grant ends by slice expiry while its request is still high.

## Operation
- All outputs are registered. Reset values: `sel`=0, `grant`=0, `valid`=0, `preempt`=0. Internal state after reset: FSM in IDLE, round-robin pointer `ptr`=0, slice counter `cnt`=0.
- FSM states are IDLE, GRANT and GAP.
- **IDLE.** `grant`=0 and `valid`=0.
  - If `en`=1 and `req`≠0, the winner is the first set bit searched from index `ptr` upward, wrapping modulo 4.
  - Next edge: load `sel`=winner, set `grant`=one-hot(winner), `valid`=1, `cnt`=0, and go to GRANT.
  - Otherwise remain in IDLE.
- **GRANT.** Outputs hold. Each cycle, `req[sel]`, `en` and `cnt` are sampled:
  - `req[sel]`=0 (release) or `en`=0: next edge go to GAP, with `preempt` staying 0.
  - Else, if `cnt`=HOLD_CYCLES−1 (expiry): next edge go to GAP and `preempt`=1 for that one cycle.
  - Else: `cnt`←`cnt`+1.
  - On every exit from GRANT: `ptr`←(`sel`+1) mod 4.
  - Release and en-low take priority over expiry, so `preempt` is 0 when they coincide.
- **GAP.** `grant`=0 and `valid`=0. `sel` holds its last value. Next edge go to IDLE unconditionally.
- Counter width is ceil(log2(HOLD_CYCLES)), minimum 1 bit. `cnt` never exceeds HOLD_CYCLES−1.
- A requester still requesting after expiry competes again in IDLE. Because `ptr` has advanced past it, other active requesters win first. If it is the sole requester, it is re-granted.
- Changes to `req` bits other than `req[sel]` during GRANT or GAP have no effect until the next IDLE arbitration.
- `rst` has priority over everything. Asserted mid-GRANT, it forces all reset values on the next edge, with no `preempt` pulse.

## Timing
- Arbitration latency: request seen in IDLE → `grant`/`valid` high on the following edge (1 cycle).
- Grant length: min(cycles until release is sampled, HOLD_CYCLES). The cycle in which release is sampled still shows `grant` high.
- Turnaround: `grant` low for exactly 2 cycles (GAP, then IDLE) between consecutive grants.
- Fully loaded throughput: HOLD_CYCLES grant cycles per HOLD_CYCLES+2 cycles.
- `preempt` is high during the first GAP cycle only.
- `valid` equals the OR of `grant` in every cycle. `grant` is never multi-hot.

## Test plan
- **Reset.** Hold `rst`=1 for 3 cycles with `req`=4'b1111 and `en`=1 → `grant`=0, `valid`=0, `sel`=0 and `preempt`=0 throughout. First grant after release is 4'b0001 one cycle later.
- **Single requester, slice expiry (HOLD_CYCLES=4).** `req`=4'b0010 held → `grant`=4'b0010 and `sel`=1 for exactly 4 cycles. `preempt` pulses on the next cycle. 2 cycles with `valid`=0 follow, then requester 1 is re-granted.
- **Round robin under full load.** `req`=4'b1111 constant → grant order is 0,1,2,3,0,1. Each grant lasts 4 cycles with a 2-cycle gap between grants. `sel` matches the index each time.
- **Early release.** `req`=4'b0101; requester 0 drops `req[0]` after its 2nd grant cycle → grant 0 lasts 3 cycles, `preempt` stays 0, and the next grant is 4'b0100.
- **Enable drop.** Deassert `en` in the 2nd grant cycle → `grant` drops on the next edge and no new grant starts while `en`=0. Reassert `en` → grant 1 cycle after IDLE samples `en`=1.
- **Reset mid-grant.** Assert `rst` during GRANT with `sel`=2 → next cycle all outputs are 0 and `ptr`=0. With `req`=4'b1100, the next grant is index 2.
